imem_loader: RTL and testbench

//  Writer side of the instruction-memory interface read by the RISC-V core's fetch/decode path.
//  - Receives a program image as a byte stream (valid/ready, e.g. from the UART receiver).
//  - Assembles little-endian 32-bit instruction words.
//  - Writes the words sequentially into instruction memory from word address 0.
//  - Holds the core in reset until the image is complete.

---
 rtl/imem_loader.sv | 200 ++++++++++++++++++++
 tb/tb_imem_loader.sv | 317 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/imem_loader.sv
// imem_loader: writer side of the instruction-memory interface.
// Takes a program image as a valid/ready byte stream, assembles little-endian
// 32-bit words, writes them to imem from word address 0 and holds the core in
// reset until the image is complete.
//
// Frame: LEN_LO, LEN_HI (word count N), N*4 data bytes LSB first, and one
// checksum byte (modulo-256 sum of data bytes) when CHECKSUM_EN is defined.
//
// Optional feature macro: CHECKSUM_EN (checksum byte and CHK state).
//
// Ports:
//   clk_i         system clock, rising edge
//   rst_n_i       synchronous active-low reset
//   rx_data_i     stream byte
//   rx_valid_i    stream byte valid
//   rx_ready_o    loader accepts a byte (LEN0, LEN1, DATA, CHK)
//   restart_i     1-cycle pulse: abort and restart the load
//   imem_we_o     imem write strobe (1-cycle pulse)
//   imem_addr_o   imem word address
//   imem_wdata_o  imem write data
//   cpu_rst_n_o   core reset, released only when the image loaded OK
//   busy_o        load in progress
//   done_o        image loaded OK (level)
//   err_o         image rejected (level)
module imem_loader #(
    parameter int ADDR_W = 8
) (
    input  logic              clk_i,
    input  logic              rst_n_i,
    input  logic [7:0]        rx_data_i,
    input  logic              rx_valid_i,
    output logic              rx_ready_o,
    input  logic              restart_i,
    output logic              imem_we_o,
    output logic [ADDR_W-1:0] imem_addr_o,
    output logic [31:0]       imem_wdata_o,
    output logic              cpu_rst_n_o,
    output logic              busy_o,
    output logic              done_o,
    output logic              err_o
);

    localparam logic [2:0] S_LEN0 = 3'd0;
    localparam logic [2:0] S_LEN1 = 3'd1;
    localparam logic [2:0] S_DATA = 3'd2;
    localparam logic [2:0] S_FIN  = 3'd3;
    localparam logic [2:0] S_DONE = 3'd4;
    localparam logic [2:0] S_ERR  = 3'd5;
`ifdef CHECKSUM_EN
    localparam logic [2:0] S_CHK  = 3'd6;
`endif

    localparam logic [16:0]       MAX_WORDS = 17'd1 << ADDR_W;
    localparam logic [ADDR_W:0]   CNT_ONE   = {{ADDR_W{1'b0}}, 1'b1};
    localparam logic [ADDR_W-1:0] ADDR_ONE  = {{(ADDR_W-1){1'b0}}, 1'b1};

    logic [2:0]        state_q, state_d;
    logic [7:0]        len_lo_q, len_lo_d;
    logic [ADDR_W:0]   nwords_q, nwords_d;
    logic [ADDR_W:0]   wcnt_q, wcnt_d;
    logic [1:0]        lane_q, lane_d;
    logic [23:0]       shift_q, shift_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              we_q, we_d;
    logic [31:0]       wdata_q, wdata_d;
`ifdef CHECKSUM_EN
    logic [7:0]        sum_q, sum_d;
`endif

    logic        xfer;
    logic [15:0] n_full;

    assign xfer   = rx_valid_i & rx_ready_o;
    assign n_full = {rx_data_i, len_lo_q};

    always_comb begin
        state_d  = state_q;
        len_lo_d = len_lo_q;
        nwords_d = nwords_q;
        wcnt_d   = wcnt_q;
        lane_d   = lane_q;
        shift_d  = shift_q;
        addr_d   = addr_q;
        we_d     = 1'b0;
        wdata_d  = wdata_q;
`ifdef CHECKSUM_EN
        sum_d    = sum_q;
`endif
        // Address advances in the cycle the write pulse is out, so the
        // pulse always carries the address of the word being written.
        if (we_q) begin
            addr_d = addr_q + ADDR_ONE;
        end

        case (state_q)
            S_LEN0: begin
                if (xfer) begin
                    len_lo_d = rx_data_i;
                    state_d  = S_LEN1;
                end
            end
            S_LEN1: begin
                if (xfer) begin
                    if (n_full == 16'd0 || {1'b0, n_full} > MAX_WORDS) begin
                        state_d = S_ERR;
                    end else begin
                        nwords_d = n_full[ADDR_W:0];
                        state_d  = S_DATA;
                    end
                end
            end
            S_DATA: begin
                if (xfer) begin
                    lane_d = lane_q + 2'd1;
`ifdef CHECKSUM_EN
                    sum_d  = sum_q + rx_data_i;
`endif
                    if (lane_q == 2'd3) begin
                        we_d    = 1'b1;
                        wdata_d = {rx_data_i, shift_q};
                        wcnt_d  = wcnt_q + CNT_ONE;
                        if (wcnt_q + CNT_ONE == nwords_q) begin
`ifdef CHECKSUM_EN
                            state_d = S_CHK;
`else
                            state_d = S_FIN;
`endif
                        end
                    end else begin
                        shift_d = {rx_data_i, shift_q[23:8]};
                    end
                end
            end
`ifdef CHECKSUM_EN
            S_CHK: begin
                if (xfer) begin
                    state_d = (rx_data_i == sum_q) ? S_DONE : S_ERR;
                end
            end
`endif
            S_FIN:   state_d = S_DONE;
            S_DONE:  state_d = S_DONE;
            S_ERR:   state_d = S_ERR;
            default: state_d = S_LEN0;
        endcase

        // Restart wins over everything in the frame, including a word that
        // completes on this very edge: its write is suppressed.
        if (restart_i) begin
            state_d = S_LEN0;
            addr_d  = '0;
            lane_d  = '0;
            wcnt_d  = '0;
            we_d    = 1'b0;
`ifdef CHECKSUM_EN
            sum_d   = '0;
`endif
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            state_q  <= S_LEN0;
            len_lo_q <= '0;
            nwords_q <= '0;
            wcnt_q   <= '0;
            lane_q   <= '0;
            shift_q  <= '0;
            addr_q   <= '0;
            we_q     <= 1'b0;
            wdata_q  <= '0;
`ifdef CHECKSUM_EN
            sum_q    <= '0;
`endif
        end else begin
            state_q  <= state_d;
            len_lo_q <= len_lo_d;
            nwords_q <= nwords_d;
            wcnt_q   <= wcnt_d;
            lane_q   <= lane_d;
            shift_q  <= shift_d;
            addr_q   <= addr_d;
            we_q     <= we_d;
            wdata_q  <= wdata_d;
`ifdef CHECKSUM_EN
            sum_q    <= sum_d;
`endif
        end
    end

    assign rx_ready_o   = !(state_q == S_FIN || state_q == S_DONE || state_q == S_ERR);
    assign busy_o       = !(state_q == S_DONE || state_q == S_ERR);
    assign done_o       = (state_q == S_DONE);
    assign err_o        = (state_q == S_ERR);
    assign cpu_rst_n_o  = (state_q == S_DONE);
    assign imem_we_o    = we_q;
    assign imem_addr_o  = addr_q;
    assign imem_wdata_o = wdata_q;

endmodule

// File: tb/tb_imem_loader.sv
// tb_imem_loader: scoreboard bench for imem_loader. A frame-level model
// predicts the imem writes and the final status; a monitor pops and compares
// every write pulse. Build with or without CHECKSUM_EN to match the DUT.
module tb_imem_loader;

    localparam int ADDR_W = 8;
    localparam int MAXW   = 1 << ADDR_W;

    typedef logic [7:0] bq_t[$];
    typedef struct packed {
        logic [ADDR_W-1:0] a;
        logic [31:0]       d;
    } wr_t;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic [7:0]        rx_data = '0;
    logic              rx_valid = 1'b0;
    logic              rx_ready;
    logic              restart = 1'b0;
    logic              imem_we;
    logic [ADDR_W-1:0] imem_addr;
    logic [31:0]       imem_wdata;
    logic              cpu_rst_n;
    logic              busy;
    logic              done;
    logic              err;

    wr_t exp_q[$];
    int  checks   = 0;
    int  errors   = 0;
    int  wr_count = 0;

    always #5 clk = ~clk;

    imem_loader #(.ADDR_W(ADDR_W)) dut (
        .clk_i        (clk),
        .rst_n_i      (rst_n),
        .rx_data_i    (rx_data),
        .rx_valid_i   (rx_valid),
        .rx_ready_o   (rx_ready),
        .restart_i    (restart),
        .imem_we_o    (imem_we),
        .imem_addr_o  (imem_addr),
        .imem_wdata_o (imem_wdata),
        .cpu_rst_n_o  (cpu_rst_n),
        .busy_o       (busy),
        .done_o       (done),
        .err_o        (err)
    );

    task automatic chk(input string name, input longint unsigned act, input longint unsigned exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: every write pulse must match the head of the scoreboard.
    always @(negedge clk) begin
        if (imem_we === 1'b1) begin
            wr_count++;
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_write actual=addr %0h data %0h expected=no write at %0t",
                         imem_addr, imem_wdata, $time);
            end else begin
                wr_t e;
                e = exp_q.pop_front();
                chk("wr_addr", imem_addr, e.a);
                chk("wr_data", imem_wdata, e.d);
            end
        end
    end

    // Frame-level reference: parse the byte image and predict writes/status.
    task automatic model(input bq_t fr, output bit exp_err);
        int n;
        logic [7:0] s;
        logic [31:0] w;
        n = int'(fr[1]) * 256 + int'(fr[0]);
        exp_err = 1'b0;
        if (n == 0 || n > MAXW) begin
            exp_err = 1'b1;
            return;
        end
        s = 8'd0;
        for (int i = 0; i < n; i++) begin
            w = {fr[2+4*i+3], fr[2+4*i+2], fr[2+4*i+1], fr[2+4*i]};
            exp_q.push_back('{a: ADDR_W'(i), d: w});
            for (int b = 0; b < 4; b++) s = s + fr[2+4*i+b];
        end
`ifdef CHECKSUM_EN
        exp_err = (fr[2+4*n] != s);
`endif
    endtask

    task automatic build_frame(input int n, input bit bad_sum, output bq_t fr);
        logic [7:0] s;
        logic [7:0] b;
        logic [15:0] n16;
        n16 = 16'(n);
        fr = {};
        fr.push_back(n16[7:0]);
        fr.push_back(n16[15:8]);
        s = 8'd0;
        for (int i = 0; i < 4 * n; i++) begin
            b = 8'($urandom);
            s = s + b;
            fr.push_back(b);
        end
`ifdef CHECKSUM_EN
        if (bad_sum) s = s + 8'($urandom_range(1, 255));
        fr.push_back(s);
`else
        if (bad_sum) s = 8'd0;
`endif
    endtask

    // All drive tasks start and end 1 time unit after a rising edge.
    task automatic send_byte(input logic [7:0] b, input int gap);
        for (int g = 0; g < gap; g++) begin
            rx_data = 8'($urandom);
            @(posedge clk); #1;
        end
        rx_valid = 1'b1;
        rx_data  = b;
        chk("rx_ready_in_frame", rx_ready, 1);
        @(posedge clk); #1;
        rx_valid = 1'b0;
    endtask

    task automatic send_frame(input bq_t fr, input int maxgap);
        foreach (fr[i]) send_byte(fr[i], $urandom_range(0, maxgap));
    endtask

    task automatic check_end(input bit exp_err);
        int k;
        k = 0;
        while (!(done || err) && k < 20) begin
            @(posedge clk); #1;
            k++;
        end
        chk("end_reached", done | err, 1);
        chk("done", done, !exp_err);
        chk("err", err, exp_err);
        chk("cpu_rst_n", cpu_rst_n, !exp_err);
        chk("rx_ready_end", rx_ready, 0);
        chk("busy_end", busy, 0);
        chk("sb_empty", exp_q.size(), 0);
    endtask

    task automatic pulse_restart();
        restart = 1'b1;
        @(posedge clk); #1;
        restart = 1'b0;
        chk("rs_ready", rx_ready, 1);
        chk("rs_busy", busy, 1);
        chk("rs_done", done, 0);
        chk("rs_err", err, 0);
        chk("rs_cpu_rst_n", cpu_rst_n, 0);
        chk("rs_addr", imem_addr, 0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog actual=running expected=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        bq_t f2, f6, fr;
        bit  e;
        int  n;

        f2 = '{8'h02, 8'h00, 8'h13, 8'h00, 8'h50, 8'h00, 8'h93, 8'h00, 8'h10, 8'h00};
`ifdef CHECKSUM_EN
        f6 = f2;
        f6.push_back(8'h07);
        f2.push_back(8'h06);
`else
        f6 = f2;
`endif

        // Reset
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_cpu_rst_n", cpu_rst_n, 0);
        chk("rst_done", done, 0);
        chk("rst_err", err, 0);
        chk("rst_we", imem_we, 0);
        chk("rst_ready", rx_ready, 1);
        chk("rst_busy", busy, 1);
        chk("rst_addr", imem_addr, 0);
        chk("rst_wdata", imem_wdata, 0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Directed two-word frame, with latency of the final status
        model(f2, e);
        wr_count = 0;
        send_frame(f2, 0);
`ifdef CHECKSUM_EN
        chk("t2_done_latency", done, 1);
`else
        chk("t2_last_we", imem_we, 1);
        chk("t2_done_early", done, 0);
        @(posedge clk); #1;
        chk("t2_done_latency", done, 1);
`endif
        check_end(e);
        chk("t2_writes", wr_count, 2);
        pulse_restart();

        // Same frame with random gaps on rx_valid
        model(f2, e);
        wr_count = 0;
        send_frame(f2, 5);
        check_end(e);
        chk("t3_writes", wr_count, 2);
        pulse_restart();

        // Zero length and oversize length
        fr = '{8'h00, 8'h00};
        model(fr, e);
        wr_count = 0;
        send_frame(fr, 0);
        chk("t4_err_now", err, 1);
        check_end(e);
        pulse_restart();
        fr = '{8'h01, 8'h01};
        model(fr, e);
        send_frame(fr, 2);
        chk("t4b_err_now", err, 1);
        check_end(e);
        chk("t4_writes", wr_count, 0);
        pulse_restart();

        // Largest legal image: every address used once
        build_frame(MAXW, 1'b0, fr);
        model(fr, e);
        wr_count = 0;
        send_frame(fr, 0);
        check_end(e);
        chk("max_writes", wr_count, MAXW);
        pulse_restart();

        // Abort mid-word, then full frame restarting at address 0
        wr_count = 0;
        send_byte(8'h02, 0); send_byte(8'h00, 0);
        send_byte(8'h13, 0); send_byte(8'h00, 0); send_byte(8'h50, 0);
        pulse_restart();
        model(f2, e);
        send_frame(f2, 1);
        check_end(e);
        chk("t5_writes", wr_count, 2);
        pulse_restart();

        // Restart on the same edge as a word's last byte: no write
        wr_count = 0;
        send_byte(8'h01, 0); send_byte(8'h00, 0);
        send_byte(8'hAA, 0); send_byte(8'hBB, 0); send_byte(8'hCC, 0);
        rx_valid = 1'b1;
        rx_data  = 8'hDD;
        restart  = 1'b1;
        @(posedge clk); #1;
        rx_valid = 1'b0;
        restart  = 1'b0;
        chk("rs_4th_no_we", imem_we, 0);
        chk("rs_4th_busy", busy, 1);
        model(f2, e);
        send_frame(f2, 0);
        check_end(e);
        chk("rs_4th_writes", wr_count, 2);
        pulse_restart();

        // Bad check byte (a normal completion when checksums are absent)
        model(f6, e);
        wr_count = 0;
        send_frame(f6, 0);
        check_end(e);
        chk("t6_writes", wr_count, 2);
        pulse_restart();

        // Randomized frames
        for (int t = 0; t < 8; t++) begin
            n = $urandom_range(1, 6);
            build_frame(n, ($urandom_range(0, 2) == 0), fr);
            model(fr, e);
            wr_count = 0;
            send_frame(fr, 3);
            check_end(e);
            chk("rand_writes", wr_count, n);
            pulse_restart();
        end

        // Reset mid-load: core stays in reset, loader back to LEN0
        send_byte(8'h02, 0); send_byte(8'h00, 0); send_byte(8'h11, 0);
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        chk("mid_rst_cpu_rst_n", cpu_rst_n, 0);
        chk("mid_rst_busy", busy, 1);
        chk("mid_rst_addr", imem_addr, 0);
        model(f2, e);
        send_frame(f2, 0);
        check_end(e);

        @(posedge clk); #1;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
